// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter for the keyboard port.
//
// Sends one command byte to the device over the shared open-drain kbdclk/kbddat lines.
// The sequence is: inhibit the clock, issue a request-to-send, then shift out the start bit,
// d0..d7 LSB first, odd parity and the stop bit on the device's clock. Finally it checks the
// device's ack bit. The scan-code receiver must ignore the lines while busy is high.
//
// Optional build macro:
//   PS2_TX_RETRY_EN  - on the first failure (NACK or timeout) of a frame, the block restarts
//                      from the inhibit phase with the same byte. err pulses only if that
//                      retry also fails.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   kbdclk     raw PS/2 clock line (asynchronous)
//   kbddat     raw PS/2 data line (asynchronous)
//   kbdclk_oe  1 pulls the clock line low
//   kbddat_oe  1 pulls the data line low
//   tx_data    byte to send, sampled on accept
//   tx_valid   request to send
//   tx_ready   high only while idle
//   busy       high whenever not idle
//   done       one-cycle pulse: frame sent and acknowledged
//   err        one-cycle pulse: NACK or device clock timeout
module ps2_host_tx #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = 12_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbdclk,
  input  logic       kbddat,
  output logic       kbdclk_oe,
  output logic       kbddat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  // Data goes low one cycle before the clock is released, so the device sees a clean
  // request-to-send (data low while clock still held low).
  localparam logic [InhW-1:0] InhDat  = InhW'(INHIBIT_CYCLES - 2);
  // Loaded with TIMEOUT_CYCLES-1 and expiring at 1, so err rises exactly TIMEOUT_CYCLES
  // edges after the edge that detects the last falling edge.
  localparam logic [ToW-1:0]  ToLoad  = ToW'(TIMEOUT_CYCLES - 1);

  if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || CLK_HZ == 0) begin : g_param_check
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StAck,
    StWaitIdle,
    StFail
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Synchronizers: clk_sync_q[2] holds the previous synchronized clock for edge detection.
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_s, dat_s, fe;
  logic       parity;
  logic       to_expired;
  logic       fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], kbdclk};
      dat_sync_q <= {dat_sync_q[0], kbddat};
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fe    = clk_sync_q[2] & ~clk_sync_q[1];

  assign parity     = ~^data_q;
  assign to_expired = !fe && (to_cnt_q == ToW'(1));

`ifdef PS2_TX_RETRY_EN
  logic retry_q, retry_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    // The gap timer restarts on every device falling edge, whatever the state.
    if (fe) begin
      to_cnt_d = ToLoad;
    end else if (to_cnt_q != '0) begin
      to_cnt_d = to_cnt_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          data_d    = tx_data;
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          dat_oe_d  = 1'b0;
          state_d   = StInhibit;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 1'b0;
`endif
        end
      end

      StInhibit: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == InhDat) begin
          dat_oe_d = 1'b1;
        end
        if (inh_cnt_q == InhLast) begin
          clk_oe_d = 1'b0;
          state_d  = StReq;
        end
      end

      StReq: begin
        to_cnt_d = ToLoad;
        state_d  = StShift;
      end

      StShift: begin
        if (fe) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < 4'd8) begin
            dat_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            dat_oe_d = ~parity;
          end else begin
            // Stop bit: release the line and let the device drive the ack.
            dat_oe_d = 1'b0;
            state_d  = StAck;
          end
        end else if (to_expired) begin
          fail = 1'b1;
        end
      end

      StAck: begin
        if (fe) begin
          if (dat_s) begin
            fail = 1'b1;
          end else begin
            state_d = StWaitIdle;
          end
        end else if (to_expired) begin
          fail = 1'b1;
        end
      end

      StWaitIdle: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (to_expired) begin
          fail = 1'b1;
        end
      end

      StFail: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (fail) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        // Single silent retry of the latched byte.
        retry_d   = 1'b1;
        clk_oe_d  = 1'b1;
        bit_cnt_d = '0;
        inh_cnt_d = '0;
        state_d   = StInhibit;
      end else begin
        err_d   = 1'b1;
        state_d = StFail;
      end
`else
      err_d   = 1'b1;
      state_d = StFail;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_q    <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign kbdclk_oe = clk_oe_q;
  assign kbddat_oe = dat_oe_q;
  assign tx_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

endmodule
